// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: hands one shared resource to one of 2**DATAWIDTH
// requesters and holds it until done, request drop, or the hold-time limit.
module rr_grant_ctrl #(
   parameter int DATAWIDTH = 3,
   parameter int MAX_HOLD  = 16,
   localparam int N        = 1 << DATAWIDTH,
   localparam int CNTW     = $clog2(MAX_HOLD + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic                 done_i,
   output logic [N-1:0]         gnt_o,
   output logic [DATAWIDTH-1:0] gnt_num_o,
   output logic                 gnt_val_o,
   output logic                 timeout_o,
   output logic                 state_o,
   output logic [DATAWIDTH-1:0] prio_ptr_o
);

   // Handshake: a requester raises req_i[k] and keeps it high for as long as it
   // wants the resource; gnt_o[k] is its "ready". Ownership ends on done_i, on
   // req_i[k] falling, or when the hold limit expires, and every grant is
   // followed by at least one idle cycle before the next one.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t               state;
   logic [DATAWIDTH-1:0] prio_ptr;
   logic [CNTW-1:0]      hold_cnt;

   logic [DATAWIDTH-1:0] win_idx;
   logic [DATAWIDTH-1:0] scan_idx;
   logic                 win_found;
   logic                 at_limit;
   logic                 owner_req;
   logic                 release_now;

   // Scan from prio_ptr upwards with natural DATAWIDTH-bit wrap; first hit wins.
   always_comb begin
      win_idx   = '0;
      scan_idx  = '0;
      win_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         scan_idx = prio_ptr + DATAWIDTH'(i);
         if (!win_found && req_i[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign at_limit    = (hold_cnt == CNTW'(MAX_HOLD));
   assign owner_req   = req_i[gnt_num_o];
   assign release_now = done_i || !owner_req || at_limit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         prio_ptr  <= '0;
         hold_cnt  <= '0;
         gnt_o     <= '0;
         gnt_num_o <= '0;
         gnt_val_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state     <= BUSY;
                  gnt_o     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                  gnt_num_o <= win_idx;
                  gnt_val_o <= 1'b1;
                  hold_cnt  <= CNTW'(1);
               end
            end
            BUSY: begin
               if (release_now) begin
                  state     <= IDLE;
                  gnt_o     <= '0;
                  gnt_val_o <= 1'b0;
                  prio_ptr  <= gnt_num_o + 1'b1;
                  hold_cnt  <= '0;
                  // Pulse only when the limit alone forced the release.
                  timeout_o <= at_limit && !done_i && owner_req;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               gnt_o     <= '0;
               gnt_val_o <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

   assign state_o    = state;
   assign prio_ptr_o = prio_ptr;

   gnt_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(gnt_o));
   gnt_val_a : assert property (@(posedge clk_i) disable iff (rst_i)
      ((gnt_o != '0) == gnt_val_o) && (gnt_val_o == (state == BUSY)));

endmodule
